// File: rtl/fifo_pkg.sv
// ============================================================================
// Module      : fifo_pkg
// Description : Shared pointer-width helper, full/empty decodes and the
//               threshold legality check for the synchronous FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    // Widest pointer the decode helpers accept (ADDR_W up to 16).
    localparam int c_MAX_PTR_W = 17;

    typedef logic [c_MAX_PTR_W-1:0] max_ptr_t;

    function automatic int ptr_width(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic logic ptr_empty(input max_ptr_t wp, input max_ptr_t rp);
        return wp == rp;
    endfunction

    // Full when the wrap bits differ and all address bits match.
    function automatic logic ptr_full(input max_ptr_t wp, input max_ptr_t rp,
                                      input int addr_w);
        logic r;
        r = 1'b1;
        for (int i = 0; i < c_MAX_PTR_W; i++) begin
            if (i < addr_w)
                r = r & (wp[i] == rp[i]);
            else if (i == addr_w)
                r = r & (wp[i] != rp[i]);
        end
        return r;
    endfunction

    function automatic bit thresholds_legal(input int addr_w, input int aempty_th,
                                            input int afull_th);
        return (aempty_th < afull_th) && (afull_th <= (2 ** addr_w)) &&
               (ptr_width(addr_w) <= c_MAX_PTR_W);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_ptr_cnt.sv
// ============================================================================
// Module      : fifo_ptr_cnt
// Description : One wrap-bit FIFO pointer with synchronous clear, increment
//               and synchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ptr_cnt #(
    parameter int PTR_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            r_ptr <= '0;
        else if (inc)
            r_ptr <= r_ptr + PTR_W'(1);
    end

    assign ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/fifo_ptr_ctrl.sv
// ============================================================================
// Module      : fifo_ptr_ctrl
// Description : Write/read pointer and status controller for the synchronous
//               FIFO. Define FIFO_PTR_CTRL_ERR_EN to build sticky
//               overflow/underflow error flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W    = 4,
    parameter int AFULL_TH  = 2 ** ADDR_W - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr,
    input  logic              rd,
    output logic              fifo_wr,
    output logic              fifo_rd,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] raddr,
    output logic              full,
    output logic              empty,
    output logic              afull,
    output logic              aempty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int c_PTR_W = ptr_width(ADDR_W);
    localparam bit c_TH_OK = thresholds_legal(ADDR_W, AEMPTY_TH, AFULL_TH);
    localparam logic [c_PTR_W-1:0] c_AFULL  = c_PTR_W'(AFULL_TH);
    localparam logic [c_PTR_W-1:0] c_AEMPTY = c_PTR_W'(AEMPTY_TH);

    if (!c_TH_OK) begin : g_bad_params
        $error("fifo_ptr_ctrl: need AEMPTY_TH < AFULL_TH <= 2**ADDR_W");
    end

    logic [c_PTR_W-1:0] w_wptr;
    logic [c_PTR_W-1:0] w_rptr;
    logic [c_PTR_W-1:0] w_count;
    logic               w_full;
    logic               w_empty;
    logic               w_active;

    assign w_full   = ptr_full(max_ptr_t'(w_wptr), max_ptr_t'(w_rptr), ADDR_W);
    assign w_empty  = ptr_empty(max_ptr_t'(w_wptr), max_ptr_t'(w_rptr));
    assign w_count  = w_wptr - w_rptr;
    assign w_active = rst_n & ~clr;

    // Qualification uses only this cycle's flags, so a full FIFO still
    // accepts a read and an empty one still accepts a write.
    assign fifo_wr = w_active & wr & ~w_full;
    assign fifo_rd = w_active & rd & ~w_empty;

    fifo_ptr_cnt #(.PTR_W(c_PTR_W)) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (fifo_wr),
        .ptr   (w_wptr)
    );

    fifo_ptr_cnt #(.PTR_W(c_PTR_W)) u_rptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (fifo_rd),
        .ptr   (w_rptr)
    );

    assign waddr  = w_wptr[ADDR_W-1:0];
    assign raddr  = w_rptr[ADDR_W-1:0];
    assign full   = w_full;
    assign empty  = w_empty;
    assign count  = w_count;
    assign afull  = (w_count >= c_AFULL);
    assign aempty = (w_count <= c_AEMPTY);

`ifdef FIFO_PTR_CTRL_ERR_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr && w_full)
                r_overflow <= 1'b1;
            if (rd && w_empty)
                r_underflow <= 1'b1;
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

`default_nettype wire
